// File: rtl/riscv_pipe_ctrl.sv
// Central pipeline control for the 5-stage RV32I core: per-stage enable, flush
// and bubble generation, per-stage valid tracking, and saturating stall/flush counters.
module riscv_pipe_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_is_load,
  input  logic             i_ex_branch_taken,
  input  logic             i_imem_stall,
  input  logic             i_dmem_stall,
  output logic             o_en_pc,
  output logic             o_en_ifid,
  output logic             o_en_idex,
  output logic             o_en_exmem,
  output logic             o_en_memwb,
  output logic             o_flush_ifid,
  output logic             o_bubble_idex,
  output logic             o_valid_id,
  output logic             o_valid_ex,
  output logic             o_valid_mem,
  output logic             o_valid_wb,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [2:0] {
    MODE_RUN,
    MODE_FETCH_WAIT,
    MODE_LOAD_USE,
    MODE_REDIRECT,
    MODE_DMEM_WAIT
  } mode_e;

  mode_e            mode;
  logic             br;
  logic             lu;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             stall_inc;
  logic             flush_inc;

  logic             valid_id_q, valid_id_d;
  logic             valid_ex_q, valid_ex_d;
  logic             valid_mem_q, valid_mem_d;
  logic             valid_wb_q, valid_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A redirect or load-use is only meaningful when EX (and ID) hold real instructions.
  assign br      = i_ex_branch_taken & valid_ex_q;
  assign rs1_hit = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
  assign rs2_hit = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
  assign lu      = valid_ex_q & valid_id_q & i_ex_is_load & i_ex_regwrite &
                   (i_ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  always_comb begin
    if (i_dmem_stall)      mode = MODE_DMEM_WAIT;
    else if (br)           mode = MODE_REDIRECT;
    else if (lu)           mode = MODE_LOAD_USE;
    else if (i_imem_stall) mode = MODE_FETCH_WAIT;
    else                   mode = MODE_RUN;
  end

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    o_en_pc       = 1'b1;
    o_en_ifid     = 1'b1;
    o_en_idex     = 1'b1;
    o_en_exmem    = 1'b1;
    o_en_memwb    = 1'b1;
    o_flush_ifid  = 1'b0;
    o_bubble_idex = 1'b0;
    unique case (mode)
      MODE_DMEM_WAIT: begin
        o_en_pc    = 1'b0;
        o_en_ifid  = 1'b0;
        o_en_idex  = 1'b0;
        o_en_exmem = 1'b0;
        o_en_memwb = 1'b0;
      end
      MODE_REDIRECT: begin
        o_flush_ifid  = 1'b1;
        o_bubble_idex = 1'b1;
      end
      MODE_LOAD_USE: begin
        o_en_pc       = 1'b0;
        o_en_ifid     = 1'b0;
        o_bubble_idex = 1'b1;
      end
      MODE_FETCH_WAIT: begin
        o_en_pc      = 1'b0;
        o_flush_ifid = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides every mode so no pipeline register captures while the core is held.
    if (!i_rstn) begin
      o_en_pc       = 1'b0;
      o_en_ifid     = 1'b0;
      o_en_idex     = 1'b0;
      o_en_exmem    = 1'b0;
      o_en_memwb    = 1'b0;
      o_flush_ifid  = 1'b0;
      o_bubble_idex = 1'b0;
    end
  end

  always_comb begin
    valid_id_d  = 1'b1;
    valid_ex_d  = valid_id_q;
    valid_mem_d = valid_ex_q;
    valid_wb_d  = valid_mem_q;
    unique case (mode)
      MODE_DMEM_WAIT: begin
        valid_id_d  = valid_id_q;
        valid_ex_d  = valid_ex_q;
        valid_mem_d = valid_mem_q;
        valid_wb_d  = valid_wb_q;
      end
      MODE_REDIRECT: begin
        valid_id_d  = 1'b0;
        valid_ex_d  = 1'b0;
        valid_mem_d = 1'b1;
      end
      MODE_LOAD_USE: begin
        valid_id_d  = valid_id_q;
        valid_ex_d  = 1'b0;
        valid_mem_d = 1'b1;
      end
      MODE_FETCH_WAIT: valid_id_d = 1'b0;
      default: ;
    endcase
  end

  assign stall_inc = (mode == MODE_DMEM_WAIT) | (mode == MODE_LOAD_USE) |
                     (mode == MODE_FETCH_WAIT);
  assign flush_inc = (mode == MODE_REDIRECT);

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_id_q  <= 1'b0;
      valid_ex_q  <= 1'b0;
      valid_mem_q <= 1'b0;
      valid_wb_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_id_q  <= valid_id_d;
      valid_ex_q  <= valid_ex_d;
      valid_mem_q <= valid_mem_d;
      valid_wb_q  <= valid_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_valid_id  = valid_id_q;
  assign o_valid_ex  = valid_ex_q;
  assign o_valid_mem = valid_mem_q;
  assign o_valid_wb  = valid_wb_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Scoreboard bench for riscv_pipe_ctrl: expected observations are queued as each
// cycle's stimulus is applied and compared when the outputs are sampled mid-cycle.
module tb_riscv_pipe_ctrl;

  typedef struct packed {
    logic       br;
    logic       dmem;
    logic       imem;
    logic       load;
    logic       regwr;
    logic [4:0] rd;
    logic       rs1u;
    logic [4:0] rs1;
    logic       rs2u;
    logic [4:0] rs2;
  } stim_t;

  // en = {pc, ifid, idex, exmem, memwb}; valid = {wb, mem, ex, id}
  typedef struct packed {
    logic [4:0]  en;
    logic        flush;
    logic        bubble;
    logic [3:0]  valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } sb_t;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU   = 5'b00111;
  localparam logic [4:0] EN_FW   = 5'b01111;

  logic clk, rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_regwrite, ex_is_load, ex_branch_taken;
  logic imem_stall, dmem_stall;

  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, bubble_idex;
  logic valid_id, valid_ex, valid_mem, valid_wb;
  logic [31:0] stall_cnt, flush_cnt;

  logic s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb, s_flush_ifid, s_bubble_idex;
  logic s_valid_id, s_valid_ex, s_valid_mem, s_valid_wb;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  sb_t sb_q[$];

  riscv_pipe_ctrl #(.CNT_W(32)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite), .i_ex_is_load(ex_is_load),
    .i_ex_branch_taken(ex_branch_taken),
    .i_imem_stall(imem_stall), .i_dmem_stall(dmem_stall),
    .o_en_pc(en_pc), .o_en_ifid(en_ifid), .o_en_idex(en_idex),
    .o_en_exmem(en_exmem), .o_en_memwb(en_memwb),
    .o_flush_ifid(flush_ifid), .o_bubble_idex(bubble_idex),
    .o_valid_id(valid_id), .o_valid_ex(valid_ex),
    .o_valid_mem(valid_mem), .o_valid_wb(valid_wb),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  riscv_pipe_ctrl #(.CNT_W(4)) dut_small (
    .i_clk(clk), .i_rstn(rstn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite), .i_ex_is_load(ex_is_load),
    .i_ex_branch_taken(ex_branch_taken),
    .i_imem_stall(imem_stall), .i_dmem_stall(dmem_stall),
    .o_en_pc(s_en_pc), .o_en_ifid(s_en_ifid), .o_en_idex(s_en_idex),
    .o_en_exmem(s_en_exmem), .o_en_memwb(s_en_memwb),
    .o_flush_ifid(s_flush_ifid), .o_bubble_idex(s_bubble_idex),
    .o_valid_id(s_valid_id), .o_valid_ex(s_valid_ex),
    .o_valid_mem(s_valid_mem), .o_valid_wb(s_valid_wb),
    .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t mk(input logic [4:0] en, input logic fl, input logic bb,
                              input logic [3:0] v, input int unsigned sc, input int unsigned fc);
    obs_t o;
    o.en = en; o.flush = fl; o.bubble = bb; o.valid = v;
    o.scnt = 32'(sc); o.fcnt = 32'(fc);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.en     = {en_pc, en_ifid, en_idex, en_exmem, en_memwb};
    o.flush  = flush_ifid;
    o.bubble = bubble_idex;
    o.valid  = {valid_wb, valid_mem, valid_ex, valid_id};
    o.scnt   = stall_cnt;
    o.fcnt   = flush_cnt;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("en=%b flush=%b bubble=%b valid(wb,mem,ex,id)=%b stall_cnt=%0d flush_cnt=%0d",
                     o.en, o.flush, o.bubble, o.valid, o.scnt, o.fcnt);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    ex_branch_taken = s.br;
    dmem_stall      = s.dmem;
    imem_stall      = s.imem;
    ex_is_load      = s.load;
    ex_regwrite     = s.regwr;
    ex_rd           = s.rd;
    id_rs1_used     = s.rs1u;
    id_rs1          = s.rs1;
    id_rs2_used     = s.rs2u;
    id_rs2          = s.rs2;
  endtask

  // Reset, then four idle cycles so every stage is valid when the caller starts.
  task automatic reset_and_fill();
    @(negedge clk);
    rstn = 1'b0;
    apply(idle());
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    obs_t got;
    sb_t  item;
    @(negedge clk);
    rstn = 1'b0;
    apply(idle());
    sb_q.push_back('{"reset_hold", mk(EN_NONE, 1'b0, 1'b0, 4'b0000, 0, 0)});
    #2;
    item = sb_q.pop_front();
    got  = sample();
    n_checks++;
    if (got !== item.v) begin
      n_errors++;
      $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
    end
    for (int k = 0; k < 6; k++) begin
      logic [3:0] v;
      @(negedge clk);
      if (k == 0) rstn = 1'b1;
      apply(idle());
      v = (k >= 4) ? 4'b1111 : 4'((1 << k) - 1);
      sb_q.push_back('{$sformatf("reset_release[%0d]", k), mk(EN_ALL, 1'b0, 1'b0, v, 0, 0)});
      #2;
      item = sb_q.pop_front();
      got  = sample();
      n_checks++;
      if (got !== item.v) begin
        n_errors++;
        $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  got;
    sb_t   item;
    reset_and_fill();
    st[0] = idle(); st[0].load = 1'b1; st[0].regwr = 1'b1; st[0].rd = 5'd5;
    st[0].rs1u = 1'b1; st[0].rs1 = 5'd3; st[0].rs2u = 1'b1; st[0].rs2 = 5'd5;
    st[1] = st[0];
    st[2] = idle();
    st[3] = idle(); st[3].load = 1'b1; st[3].regwr = 1'b1; st[3].rd = 5'd0;
    st[3].rs2u = 1'b1; st[3].rs2 = 5'd0;
    st[4] = idle();
    ex[0] = mk(EN_LU,  1'b0, 1'b1, 4'b1111, 0, 0);
    ex[1] = mk(EN_ALL, 1'b0, 1'b0, 4'b1101, 1, 0);
    ex[2] = mk(EN_ALL, 1'b0, 1'b0, 4'b1011, 1, 0);
    ex[3] = mk(EN_ALL, 1'b0, 1'b0, 4'b0111, 1, 0);
    ex[4] = mk(EN_ALL, 1'b0, 1'b0, 4'b1111, 1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      apply(st[k]);
      sb_q.push_back('{$sformatf("load_use[%0d]", k), ex[k]});
      #2;
      item = sb_q.pop_front();
      got  = sample();
      n_checks++;
      if (got !== item.v) begin
        n_errors++;
        $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
      end
    end
  endtask

  task automatic test_redirect_priority();
    stim_t st[4];
    obs_t  ex[4];
    obs_t  got;
    sb_t   item;
    reset_and_fill();
    st[0] = idle(); st[0].br = 1'b1; st[0].imem = 1'b1;
    st[0].load = 1'b1; st[0].regwr = 1'b1; st[0].rd = 5'd7;
    st[0].rs1u = 1'b1; st[0].rs1 = 5'd7;
    st[1] = st[0]; st[1].imem = 1'b0;
    st[2] = idle();
    st[3] = idle();
    ex[0] = mk(EN_ALL, 1'b1, 1'b1, 4'b1111, 0, 0);
    ex[1] = mk(EN_ALL, 1'b0, 1'b0, 4'b1100, 0, 1);
    ex[2] = mk(EN_ALL, 1'b0, 1'b0, 4'b1001, 0, 1);
    ex[3] = mk(EN_ALL, 1'b0, 1'b0, 4'b0011, 0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      apply(st[k]);
      sb_q.push_back('{$sformatf("redirect[%0d]", k), ex[k]});
      #2;
      item = sb_q.pop_front();
      got  = sample();
      n_checks++;
      if (got !== item.v) begin
        n_errors++;
        $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
      end
    end
  endtask

  task automatic test_dmem_wait();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  got;
    sb_t   item;
    reset_and_fill();
    for (int k = 0; k < 3; k++) begin
      st[k] = idle(); st[k].dmem = 1'b1; st[k].br = 1'b1;
      ex[k] = mk(EN_NONE, 1'b0, 1'b0, 4'b1111, k, 0);
    end
    st[3] = idle(); st[3].br = 1'b1;
    st[4] = idle();
    ex[3] = mk(EN_ALL, 1'b1, 1'b1, 4'b1111, 3, 0);
    ex[4] = mk(EN_ALL, 1'b0, 1'b0, 4'b1100, 3, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      apply(st[k]);
      sb_q.push_back('{$sformatf("dmem_wait[%0d]", k), ex[k]});
      #2;
      item = sb_q.pop_front();
      got  = sample();
      n_checks++;
      if (got !== item.v) begin
        n_errors++;
        $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
      end
    end
  endtask

  task automatic test_imem_wait();
    stim_t st[7];
    obs_t  ex[7];
    obs_t  got;
    sb_t   item;
    reset_and_fill();
    st[0] = idle(); st[0].imem = 1'b1;
    st[1] = st[0];
    for (int k = 2; k < 7; k++) st[k] = idle();
    ex[0] = mk(EN_FW,  1'b1, 1'b0, 4'b1111, 0, 0);
    ex[1] = mk(EN_FW,  1'b1, 1'b0, 4'b1110, 1, 0);
    ex[2] = mk(EN_ALL, 1'b0, 1'b0, 4'b1100, 2, 0);
    ex[3] = mk(EN_ALL, 1'b0, 1'b0, 4'b1001, 2, 0);
    ex[4] = mk(EN_ALL, 1'b0, 1'b0, 4'b0011, 2, 0);
    ex[5] = mk(EN_ALL, 1'b0, 1'b0, 4'b0111, 2, 0);
    ex[6] = mk(EN_ALL, 1'b0, 1'b0, 4'b1111, 2, 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      apply(st[k]);
      sb_q.push_back('{$sformatf("imem_wait[%0d]", k), ex[k]});
      #2;
      item = sb_q.pop_front();
      got  = sample();
      n_checks++;
      if (got !== item.v) begin
        n_errors++;
        $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
      end
    end
  endtask

  task automatic test_saturation_and_async_reset();
    stim_t s;
    obs_t  got;
    sb_t   item;
    int unsigned exp_small;
    s = idle(); s.imem = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    apply(idle());
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) rstn = 1'b1;
      apply(s);
      sb_q.push_back('{$sformatf("imem_long[%0d]", k), mk(EN_FW, 1'b1, 1'b0, 4'b0000, k, 0)});
      exp_small = (k > 15) ? 15 : k;
      #2;
      item = sb_q.pop_front();
      got  = sample();
      n_checks++;
      if (got !== item.v) begin
        n_errors++;
        $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
      end
      n_checks++;
      if (s_stall_cnt !== 4'(exp_small)) begin
        n_errors++;
        $display("FAIL sat_stall_cnt[%0d]: got %0d, expected %0d", k, s_stall_cnt, exp_small);
      end
    end
    // Assert reset between clock edges while the fetch stall is still active.
    #1;
    rstn = 1'b0;
    sb_q.push_back('{"async_reset_mid_stall", mk(EN_NONE, 1'b0, 1'b0, 4'b0000, 0, 0)});
    #1;
    item = sb_q.pop_front();
    got  = sample();
    n_checks++;
    if (got !== item.v) begin
      n_errors++;
      $display("FAIL %s: got %s, expected %s", item.name, fmt(got), fmt(item.v));
    end
    n_checks++;
    if ({s_en_pc, s_en_ifid, s_flush_ifid, s_stall_cnt, s_flush_cnt} !== 11'd0) begin
      n_errors++;
      $display("FAIL async_reset_small: got en_pc=%b en_ifid=%b flush=%b stall_cnt=%0d flush_cnt=%0d, expected all 0",
               s_en_pc, s_en_ifid, s_flush_ifid, s_stall_cnt, s_flush_cnt);
    end
    @(negedge clk);
    apply(idle());
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    apply(idle());
    test_reset();
    test_load_use();
    test_redirect_priority();
    test_dmem_wait();
    test_imem_wait();
    test_saturation_and_async_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_pipe_ctrl.md
# riscv_pipe_ctrl

Central pipeline control for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Generates the per-stage enable, flush and bubble controls that drive the inter-stage pipeline registers, and tracks a valid bit per stage. Resolves data-memory wait, taken branch/jump redirect, load-use hazard and instruction-memory wait under a fixed priority. Maintains saturating stall and flush performance counters.

## Interface
- CNT_W, default 32, width of the performance counters.

- i_clk  input  1  core clock, rising edge.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_id_rs1, i_id_rs2  input  5 each  source register indices of the instruction in ID.
- i_id_rs1_used, i_id_rs2_used  input  1 each  ID instruction reads rs1 / rs2.
- i_ex_rd  input  5  destination register of the instruction in EX.
- i_ex_regwrite  input  1  EX instruction writes rd.
- i_ex_is_load  input  1  EX instruction is a load.
- i_ex_branch_taken  input  1  EX resolved a taken branch/jump; PC mux selects target.
- i_imem_stall  input  1  fetch data not available this cycle.
- i_dmem_stall  input  1  data memory access in MEM not complete this cycle.
- o_en_pc, o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb  output  1 each  pipeline register enables (combinational).
- o_flush_ifid  output  1  load NOP into IF/ID when o_en_ifid=1 (combinational).
- o_bubble_idex  output  1  load NOP (control bits zero) into ID/EX when o_en_idex=1 (combinational).
- o_valid_id, o_valid_ex, o_valid_mem, o_valid_wb  output  1 each  stage holds a real instruction (registered).
- o_stall_cnt  output  CNT_W  cycles with o_en_pc=0 outside reset (registered).
- o_flush_cnt  output  CNT_W  accepted taken redirects (registered).

## Operation
- Internal terms: br = i_ex_branch_taken & o_valid_ex; lu = o_valid_ex & o_valid_id & i_ex_is_load & i_ex_regwrite & (i_ex_rd != 0) & ((i_id_rs1_used & i_id_rs1 == i_ex_rd) | (i_id_rs2_used & i_id_rs2 == i_ex_rd)).
- Priority, highest first; exactly one mode per cycle:
- DMEM_WAIT (i_dmem_stall): all five enables 0, flush/bubble 0; valid bits and counters other than o_stall_cnt hold. A pending br or lu is re-evaluated next cycle (EX frozen).
- REDIRECT (br): all enables 1, o_flush_ifid=1, o_bubble_idex=1. Overrides lu and i_imem_stall. Next: valid_id=0, valid_ex=0, valid_mem=1, valid_wb=old valid_mem. o_flush_cnt +1.
- LOAD_USE (lu): o_en_pc=0, o_en_ifid=0, o_en_idex=1 with o_bubble_idex=1, o_en_exmem=o_en_memwb=1. Next: valid_id holds, valid_ex=0, valid_mem=1, valid_wb=old valid_mem. Exactly one bubble per load (after it, the load is in MEM and lu is false).
- FETCH_WAIT (i_imem_stall): o_en_pc=0, o_en_ifid=1 with o_flush_ifid=1, rest enabled. Next: valid_id=0, others shift.
- RUN: all enables 1, flush/bubble 0. Next: valid_id=1, valid_ex=old valid_id, valid_mem=old valid_ex, valid_wb=old valid_mem.
- o_stall_cnt increments in DMEM_WAIT, LOAD_USE, FETCH_WAIT; both counters saturate at 2^CNT_W-1 (no wrap).
- rd=x0 never causes a load-use stall.

## Timing
- Reset (i_rstn=0, async): all valid bits 0, both counters 0; while reset is low all enables, o_flush_ifid and o_bubble_idex are forced 0.
- First posedge after reset release with no stalls: o_valid_id=1; o_valid_wb first 1 after the 4th posedge.
- Mode decision is combinational from inputs and current valid bits in the same cycle; valid bits and counters update on the following rising edge.
- Redirect penalty: 2 bubbles (ID, EX invalid). Load-use penalty: 1 cycle. Memory waits: 1 cycle per asserted cycle.
- Reset asserted mid-stall or mid-redirect: state clears immediately; no pending event is remembered.

## Test plan
- Reset release, no stalls, 6 cycles -> all enables 1; valid_id/ex/mem/wb become 1 after posedge 1/2/3/4; counters stay 0.
- EX: load rd=5, ID: rs2_used, rs2=5 -> exactly one cycle o_en_pc=0, o_en_ifid=0, o_bubble_idex=1; next cycle RUN; o_valid_ex=0 for one cycle; o_stall_cnt=1. Same with rd=0 -> no stall.
- Taken branch in valid EX with simultaneous lu and i_imem_stall -> REDIRECT chosen: flush_ifid=bubble_idex=1, all enables 1; next valid_id=valid_ex=0; o_flush_cnt=1, o_stall_cnt=0.
- i_dmem_stall for 3 cycles with branch pending in EX -> 3 cycles all enables 0, valid bits frozen, o_stall_cnt=3; redirect taken on cycle 4, o_flush_cnt=1.
- i_imem_stall for 2 cycles in steady state -> o_en_pc=0, o_flush_ifid=1 twice; two invalid slots propagate ID->WB; o_stall_cnt=2.
- CNT_W=4, 20 imem-stall cycles -> o_stall_cnt saturates at 15; assert i_rstn low mid-stall -> enables 0 immediately, counters and valid bits 0.
